sram_like_slave: RTL and testbench
==================================

# sram_like_slave

Responder end of the SRAM-like request/response protocol driven by the fetch and memory stages (`req`/`addr_ok`/`data_ok`). It accepts address-phase handshakes and issues each accepted access to a single-cycle synchronous RAM. It buffers read data and returns responses strictly in request order, with a bounded number of outstanding transactions. It sits between a pipeline stage and the on-chip instruction/data RAM. It also serves as the bench-side memory model for exercising stage-side cancel/discard logic.

## Interface
Parameters:
- `RAM_AW`, 14 — RAM word-address width; RAM holds 2^RAM_AW 32-bit words.
- `MAX_OUT`, 2 — maximum outstanding transactions (accepted, `data_ok` not yet given); legal 1..4.
- `LFSR_SEED`, 16'hACE1 — nonzero seed for the delay LFSR (used only with `SRAM_RAND_DELAY_EN`).

Ports:
- `clk` in 1 — clock, rising edge.
- `reset` in 1 — asynchronous, active-high reset.
- `req` in 1 — request valid.
- `wr` in 1 — 1 = write, 0 = read.
- `size` in 2 — 0 = byte, 1 = half, 2 = word.
- `wstrb` in 4 — byte write enables.
- `addr` in 32 — byte address.
- `wdata` in 32 — write data.
- `addr_ok` out 1 — address-phase accept.
- `data_ok` out 1 — response valid, one per accepted request.
- `rdata` out 32 — read data; 0 for write responses.
- `ram_en` out 1 — RAM access enable.
- `ram_we` out 4 — RAM byte write enables.
- `ram_addr` out RAM_AW — RAM word address = `addr[RAM_AW+1:2]`.
- `ram_wdata` out 32 — equals `wdata`.
- `ram_rdata` in 32 — RAM read data, valid the cycle after `ram_en`.

## Operation
- Handshake: a transaction is accepted in a cycle with `req & addr_ok`. The initiator holds the request until accepted. `data_ok` has no back-pressure; the initiator always consumes it.
- Outstanding counter `out_cnt` (0..MAX_OUT):
  - Increments on accept.
  - Decrements on `data_ok`.
  - Unchanged when both occur in the same cycle.
  - `addr_ok = (out_cnt < MAX_OUT)`, gated as described in Configuration.
- On accept, in the same cycle: `ram_en=1`, `ram_we = wr ? wstrb : 4'b0`. No RAM access occurs in any other cycle.
- A 1-bit stage register `pend_v`/`pend_wr` marks the access in flight. On the next cycle, {wr, wr ? 0 : ram_rdata} is pushed into the response FIFO (depth MAX_OUT).
- `data_ok` = FIFO non-empty (gated as described in Configuration). `rdata` is the head entry's data. Each `data_ok` pops exactly one entry.
- The FIFO cannot overflow: `out_cnt` bounds FIFO occupancy plus in-flight accesses to MAX_OUT.
- Sizes are not checked against the address. `wstrb` is trusted as given, and `size` is ignored apart from being forwarded in the protocol.
- Reset asserted at any time:
  - `out_cnt=0`, FIFO empty, `pend_v=0`.
  - In-flight transactions are dropped and no `data_ok` is ever produced for them.
  - LFSR reloads `LFSR_SEED`.

## Timing
- Reset values: `addr_ok=0` while `reset` is high, then 1 on the first cycle after release; `data_ok=0`, `rdata=0`, `ram_en=0`, `ram_we=0`.
- Minimum latency: accept in cycle N gives `data_ok` in cycle N+2.
- Throughput: one accept per cycle is sustained with `MAX_OUT>=2` and no delay.
- At full (`out_cnt==MAX_OUT`), `addr_ok=0` unless `data_ok` is high that cycle, in which case `addr_ok=1`. The counter is computed from next occupancy and the path from `data_ok` to `addr_ok` is combinational.
- Empty FIFO with `pend_v=1`: `data_ok=0` this cycle and `data_ok=1` next cycle.

## Configuration
- `SRAM_RAND_DELAY_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
  - `addr_ok` is additionally ANDed with `lfsr[0]`.
  - `data_ok` is additionally ANDed with `lfsr[3]`.
  - Ordering and counts are unchanged; only latency varies.
- Undefined: no LFSR logic. `addr_ok`/`data_ok` follow the base rules exactly.

## Structure
- Package `sram_like_pkg`:
  - `SIZE_B`/`SIZE_H`/`SIZE_W` constants.
  - `resp_t` struct {wr, data[31:0]}.
  - LFSR tap constant.
- Sub-module `sram_resp_fifo`: synchronous FIFO of `resp_t` with parameter depth, push/pop/empty/full, asynchronous active-high reset.

## Test plan
- Single read: RAM[0x10]=0xDEADBEEF; `req`, `addr=0x40`, `wr=0` accepted at cycle 5 -> `ram_en`=1 with `ram_addr=0x10` at cycle 5; `data_ok`=1 with `rdata=0xDEADBEEF` at cycle 7 only.
- Back-to-back reads to 0x0, 0x4, 0x8 with `MAX_OUT=2` -> first two accepts consecutive; third `addr_ok` waits for the first `data_ok`; three responses in order.
- Write then read: write `addr=0x100`, `wstrb=4'b0011`, `wdata=0x12345678` onto RAM initialized 0xFFFFFFFF -> write `data_ok` with `rdata=0`; following read returns 0xFFFF5678.
- Reset mid-flight: assert `reset` the cycle after an accept -> no `data_ok` ever for it; `addr_ok`=1 the first cycle after release; `out_cnt=0`.
- Simultaneous pop and accept at full (`MAX_OUT=2`) -> `addr_ok`=1 that cycle; `out_cnt` stays 2; no lost or duplicated response over 100 random requests.
- `SRAM_RAND_DELAY_EN` defined, 1000 random requests -> response count equals accept count, order preserved, `out_cnt` never exceeds MAX_OUT.

Source files
------------

// File: rtl/sram_like_pkg.sv
// Shared types and constants for the SRAM-like responder: size codes,
// response payload and delay-LFSR taps.
package sram_like_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] data;
  } resp_t;

  function automatic logic lfsr_fb(input logic [15:0] state);
    return ^(state & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// In-order response buffer between the RAM stage register and data_ok.
module sram_resp_fifo
  import sram_like_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  logic  pop,
  input  resp_t din,
  output resp_t dout,
  output logic  empty,
  output logic  full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  resp_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Payload storage needs no reset; dout is only consumed when non-empty
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/sram_like_slave.sv
// SRAM-like protocol responder in front of a single-cycle synchronous RAM.
// Optional macro SRAM_RAND_DELAY_EN adds LFSR-driven stalls on addr_ok/data_ok.
module sram_like_slave
  import sram_like_pkg::*;
#(
  parameter int unsigned RAM_AW    = 14,
  parameter int unsigned MAX_OUT   = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int unsigned CNT_W = 3;

  logic [CNT_W-1:0] out_cnt;
  logic             pend_v;
  logic             pend_wr;
  logic             accept;
  logic             fifo_empty;
  logic             fifo_full;
  logic             gate_a;
  logic             gate_d;
  resp_t            push_data;
  resp_t            head;
  logic             unused_bits;

`ifdef SRAM_RAND_DELAY_EN
  logic [15:0] lfsr;

  // Free-running stall generator; reloads its seed on every reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb(lfsr)};
    end
  end

  assign gate_a = lfsr[0];
  assign gate_d = lfsr[3];
  assign unused_bits = ^{size == SIZE_B, size == SIZE_H, size == SIZE_W,
                         addr[1:0], addr[31:RAM_AW+2]};
`else
  assign gate_a = 1'b1;
  assign gate_d = 1'b1;
  assign unused_bits = ^{size == SIZE_B, size == SIZE_H, size == SIZE_W,
                         addr[1:0], addr[31:RAM_AW+2], LFSR_SEED};
`endif

  // A pop this cycle frees a slot, so a full responder may still accept
  assign data_ok = ~fifo_empty & gate_d;
  assign addr_ok = ~reset & gate_a & ((out_cnt < CNT_W'(MAX_OUT)) | data_ok);
  assign accept  = req & addr_ok;

  assign ram_en    = accept;
  assign ram_we    = (accept & wr) ? wstrb : 4'b0000;
  assign ram_addr  = addr[RAM_AW+1:2];
  assign ram_wdata = wdata;

  // Outstanding count and the one-deep RAM stage marker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_cnt <= '0;
      pend_v  <= 1'b0;
      pend_wr <= 1'b0;
    end else begin
      case ({accept, data_ok})
        2'b10:   out_cnt <= out_cnt + CNT_W'(1);
        2'b01:   out_cnt <= out_cnt - CNT_W'(1);
        default: out_cnt <= out_cnt;
      endcase
      pend_v  <= accept;
      pend_wr <= accept & wr;
    end
  end

  assign push_data.wr   = pend_wr;
  assign push_data.data = pend_wr ? 32'h0 : ram_rdata;

  sram_resp_fifo #(
    .DEPTH (MAX_OUT)
  ) u_resp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pend_v),
    .pop   (data_ok),
    .din   (push_data),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign rdata = data_ok ? head.data : 32'h0;

endmodule

// File: tb/tb_sram_like_slave.sv
// Self-checking bench for sram_like_slave: RAM model, in-order response scoreboard,
// directed vector table, reset corner cases and randomized traffic.
`timescale 1ns/1ps
module tb_sram_like_slave;

  localparam int unsigned RAM_AW  = 14;
  localparam int unsigned MAX_OUT = 2;
  localparam int unsigned WORDS   = 1 << RAM_AW;
`ifdef SRAM_RAND_DELAY_EN
  localparam int N_RAND = 1000;
`else
  localparam int N_RAND = 150;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req = 1'b0;
  logic              wr = 1'b0;
  logic [1:0]        size = 2'd2;
  logic [3:0]        wstrb = 4'h0;
  logic [31:0]       addr = 32'h0;
  logic [31:0]       wdata = 32'h0;
  logic              addr_ok;
  logic              data_ok;
  logic [31:0]       rdata;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = 32'h0;

  sram_like_slave #(
    .RAM_AW    (RAM_AW),
    .MAX_OUT   (MAX_OUT),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .wr        (wr),
    .size      (size),
    .wstrb     (wstrb),
    .addr      (addr),
    .wdata     (wdata),
    .addr_ok   (addr_ok),
    .data_ok   (data_ok),
    .rdata     (rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int unsigned i);
    if (i == 32'h10) return 32'hDEADBEEF;
    if (i < 3) return 32'h1111_1111 * (i + 1);
    return 32'hFFFF_FFFF;
  endfunction

  // Bench-side synchronous RAM, driven only by the DUT's RAM port
  logic [31:0] ram [WORDS];
  logic        ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < int'(WORDS); i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else if (ram_en) begin
      ram_rdata <= ram[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  // Reference model: flat memory image plus queue of expected responses
  typedef struct {
    logic        wr;
    logic [31:0] data;
    int          ready;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  logic [31:0] model_mem [WORDS];
  exp_t        q[$];
  vec_t        vecs[9];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          n_acc = 0;
  int          n_resp = 0;
  int          full_swap = 0;
  int          last_resp_cyc = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        tick_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: inputs already driven after the falling edge
  task automatic tick();
    logic        head_ok;
    logic        exp_dok;
    logic        exp_aok;
    logic        acc;
    logic        was_full;
    int unsigned w;
    exp_t        e;
    #1;
    head_ok = !reset && (q.size() > 0) && (q[0].ready <= cyc);
`ifdef SRAM_RAND_DELAY_EN
    exp_dok = head_ok ? data_ok : 1'b0;
    exp_aok = (!reset && (q.size() < int'(MAX_OUT) || data_ok)) ? addr_ok : 1'b0;
`else
    exp_dok = head_ok;
    exp_aok = !reset && (q.size() < int'(MAX_OUT) || exp_dok);
`endif
    chk("data_ok", 32'(data_ok), 32'(exp_dok));
    chk("rdata", rdata, (data_ok && head_ok) ? q[0].data : 32'h0);
    chk("addr_ok", 32'(addr_ok), 32'(exp_aok));
    acc = req & addr_ok;
    chk("ram_en", 32'(ram_en), 32'(acc));
    chk("ram_we", 32'(ram_we), (acc && wr) ? 32'(wstrb) : 32'h0);
    chk("ram_wdata", ram_wdata, wdata);
    if (acc) chk("ram_addr", 32'(ram_addr), 32'(addr[RAM_AW+1:2]));
    tick_acc = 1'b0;
    if (reset) begin
      q.delete();
    end else begin
      was_full = (q.size() == int'(MAX_OUT));
      if (data_ok && q.size() > 0) begin
        last_rdata    = rdata;
        last_resp_cyc = cyc;
        n_resp++;
        if (was_full && acc) full_swap++;
        void'(q.pop_front());
      end
      if (acc) begin
        w       = 32'(addr[RAM_AW+1:2]);
        e.wr    = wr;
        e.data  = wr ? 32'h0 : model_mem[w];
        e.ready = cyc + 2;
        q.push_back(e);
        if (wr)
          for (int b = 0; b < 4; b++)
            if (wstrb[b]) model_mem[w][8*b +: 8] = wdata[8*b +: 8];
        n_acc++;
        tick_acc = 1'b1;
      end
      chk("out_bound", 32'(q.size() <= int'(MAX_OUT)), 32'd1);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic issue(input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, output int acc_cyc);
    req   = 1'b1;
    wr    = w;
    wstrb = s;
    addr  = a;
    wdata = d;
    acc_cyc = -1;
    for (int k = 0; k < 200 && acc_cyc < 0; k++) begin
      tick();
      if (tick_acc) acc_cyc = cyc - 1;
    end
    if (acc_cyc < 0) chk("accept_timeout", 32'd0, 32'd1);
    req = 1'b0;
    wr  = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && q.size() > 0; k++) tick();
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, acc, r0, n0;

    vecs[0] = '{1'b0, 4'h0, 32'h0000_0040, 32'h0,          32'hDEADBEEF};
    vecs[1] = '{1'b1, 4'h3, 32'h0000_0100, 32'h1234_5678,  32'h0};
    vecs[2] = '{1'b0, 4'h0, 32'h0000_0100, 32'h0,          32'hFFFF_5678};
    vecs[3] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,          32'h1111_1111};
    vecs[4] = '{1'b1, 4'hC, 32'h0000_0004, 32'hAABB_CCDD,  32'h0};
    vecs[5] = '{1'b0, 4'h0, 32'h0000_0004, 32'h0,          32'hAABB_2222};
    vecs[6] = '{1'b1, 4'hF, 32'h0000_0008, 32'h0,          32'h0};
    vecs[7] = '{1'b0, 4'h0, 32'h0000_0008, 32'h0,          32'h0};
    vecs[8] = '{1'b0, 4'h0, 32'hFFFF_0041, 32'h0,          32'hDEADBEEF};
    for (int i = 0; i < int'(WORDS); i++) model_mem[i] = init_word(i);

    // Reset values
    @(negedge clk);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("aok_after_release", 32'(addr_ok), 32'd1);
    tick();

    // Back-to-back reads with MAX_OUT=2
    n0 = n_resp;
    issue(1'b0, 4'h0, 32'h0, 32'h0, a0);
    issue(1'b0, 4'h0, 32'h4, 32'h0, a1);
    issue(1'b0, 4'h0, 32'h8, 32'h0, a2);
    drain();
    chk("b2b_consecutive", 32'(a1 - a0), 32'd1);
`ifndef SRAM_RAND_DELAY_EN
    chk("b2b_third_wait", 32'(a2 - a0), 32'd2);
`endif
    chk("b2b_resp_count", 32'(n_resp - n0), 32'd3);
    repeat (2) tick();

    // Directed vector table
    foreach (vecs[i]) begin
      issue(vecs[i].wr, vecs[i].wstrb, vecs[i].addr, vecs[i].wdata, acc);
      drain();
      chk("vec_rdata", last_rdata, vecs[i].exp);
`ifndef SRAM_RAND_DELAY_EN
      chk("vec_latency", 32'(last_resp_cyc - acc), 32'd2);
`endif
      tick();
    end

    // Reset asserted the cycle after an accept drops the transaction
    n0 = n_resp;
    issue(1'b0, 4'h0, 32'h40, 32'h0, acc);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("rst_mid_aok", 32'(addr_ok), 32'd1);
    repeat (6) tick();
    chk("rst_mid_no_resp", 32'(n_resp - n0), 32'd0);

    // Randomized traffic
    n0 = n_acc;
    r0 = n_resp;
    for (int k = 0; k < 40000 && (n_acc - n0) < N_RAND; k++) begin
      if (!req && $urandom_range(0, 3) != 0) begin
        req   = 1'b1;
        wr    = 1'($urandom_range(0, 1));
        wstrb = 4'($urandom);
        wdata = $urandom;
        addr  = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 63)) << 2)
                | 32'($urandom_range(0, 3));
      end
      tick();
      if (tick_acc) req = 1'b0;
    end
    req = 1'b0;
    drain();
    chk("rand_accepts", 32'(n_acc - n0), 32'(N_RAND));
    chk("rand_resp_eq_acc", 32'(n_resp - r0), 32'(n_acc - n0));
`ifndef SRAM_RAND_DELAY_EN
    chk("full_swap_seen", 32'(full_swap > 0), 32'd1);
`endif
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
